// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM state encoding and R/W bit values.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK,
    PTR,
    WDATA,
    RDATA,
    MACK,
    IGNORE
  } i2c_state_e;

  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_input_filter.sv
// Two-flop synchroniser followed by a stability filter; emits the accepted level plus
// single-cycle rise/fall strobes that coincide with the level update.
module i2c_input_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic in_raw,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples that disagree with the accepted level
  always_comb begin
    lvl_d  = lvl_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) begin
        lvl_d  = sync2_q;
        rise_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Idle bus level is high, so reset to 1 to avoid a spurious edge after reset
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing NREG 8-bit registers through a pointer-byte protocol.
// SDA is only ever pulled low; SCL is never stretched.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR7    = 7'h42,
  parameter int         NREG     = 8,
  parameter int         FILT_LEN = 4,
  localparam int        PW       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              scl_oe,
  output logic              sda_oe,
  output logic [8*NREG-1:0] regs_out,
  output logic              wr_pulse,
  output logic [PW-1:0]     wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_input_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .in_raw       (scl_in),
    .lvl          (scl_lvl),
    .rise         (scl_rise),
    .fall         (scl_fall)
  );

  i2c_input_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .in_raw       (sda_in),
    .lvl          (sda_lvl),
    .rise         (sda_rise),
    .fall         (sda_fall)
  );

  i2c_state_e    state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rw_q, rw_d;
  logic          ptr_seen_q, ptr_seen_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_pulse_q, wr_pulse_d;
  logic [PW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    regs_q [NREG];
  logic [7:0]    regs_d [NREG];

  logic [7:0] rx_byte, rd_byte;
  logic       start_det, stop_det;

  assign rx_byte   = {shreg_q[6:0], sda_lvl};
  assign rd_byte   = regs_q[ptr_q];
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    rw_d       = rw_q;
    ptr_seen_d = ptr_seen_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;
    // Register file commits one cycle after the strobe is visible
    if (wr_pulse_q) regs_d[wr_addr_q] = wr_data_q;

    case (state_q)
      ADDR, PTR, WDATA: begin
        if (scl_rise) begin
          shreg_d  = rx_byte;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7 && state_q == PTR) begin
            ptr_d      = rx_byte[PW-1:0];
            ptr_seen_d = 1'b1;
          end
          if (bitcnt_q == 4'd7 && state_q == WDATA) begin
            wr_pulse_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = rx_byte;
            ptr_d      = ptr_q + PW'(1);
          end
        end else if (scl_fall && bitcnt_q == 4'd8) begin
          if (state_q != ADDR) begin
            state_d  = ACK;
            sda_oe_d = 1'b1;
          end else if (shreg_q[7:1] == ADDR7) begin
            state_d  = ACK;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            rw_d     = shreg_q[0];
          end else begin
            state_d = IGNORE;
          end
        end
      end
      ACK: begin
        if (scl_fall) begin
          bitcnt_d = '0;
          sda_oe_d = 1'b0;
          if (rw_q == I2C_RD) begin
            state_d  = RDATA;
            shreg_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end else if (ptr_seen_q) begin
            state_d = WDATA;
          end else begin
            state_d = PTR;
          end
        end
      end
      RDATA: begin
        if (scl_rise) begin
          bitcnt_d = bitcnt_q + 4'd1;
        end else if (scl_fall) begin
          if (bitcnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            bitcnt_d = '0;
            state_d  = MACK;
          end else begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            sda_oe_d = ~shreg_q[6];
          end
        end
      end
      MACK: begin
        // bitcnt 9 marks "master acknowledged; reload on the coming falling edge"
        if (scl_rise) begin
          if (sda_lvl) begin
            state_d = IGNORE;
          end else begin
            ptr_d    = ptr_q + PW'(1);
            bitcnt_d = 4'd9;
          end
        end else if (scl_fall && bitcnt_q == 4'd9) begin
          state_d  = RDATA;
          bitcnt_d = '0;
          shreg_d  = rd_byte;
          sda_oe_d = ~rd_byte[7];
        end
      end
      default: ;
    endcase

    if (start_det) begin
      state_d    = ADDR;
      bitcnt_d   = '0;
      sda_oe_d   = 1'b0;
      ptr_seen_d = 1'b0;
    end
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      rw_q       <= I2C_WR;
      ptr_seen_q <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      rw_q       <= rw_d;
      ptr_seen_q <= ptr_seen_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_regs_out
    assign regs_out[8*k +: 8] = regs_q[k];
  end

  assign scl_oe   = 1'b0;
  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule
